// File: rtl/l1dcache_core_if.sv
// Core-side request/response bundle of the L1 data cache.
// The core drives requests (master); the cache answers one cycle later (slave).
interface l1dcache_core_if;
  logic        req_valid;
  logic        req_we;
  logic [29:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic        resp_ack;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_data, req_mask,
    input  resp_ack, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_mask,
    output resp_ack, resp_data
  );
endinterface

// File: rtl/l1dcache_core.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Requests are answered with a registered ack the following cycle; anything
// that cannot complete is nacked and replayed by the core. Misses refill a
// whole line word by word over the backing port; stores go out through a
// single-entry write buffer.
module l1dcache_core #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  l1dcache_core_if.slave core,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int LINE_W = 30 - OFF_W;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                   state_q, state_d;
  logic [NUM_LINES-1:0]     valid_q, valid_d;
  logic                     resp_ack_q, resp_ack_d;
  logic [31:0]              resp_data_q, resp_data_d;
  logic                     wb_full_q, wb_full_d;
  logic [29:0]              wb_addr_q, wb_addr_d;
  logic [31:0]              wb_data_q, wb_data_d;
  logic [3:0]               wb_mask_q, wb_mask_d;
  logic [LINE_W-1:0]        line_q, line_d;
  logic [OFF_W-1:0]         cnt_q, cnt_d;
  logic                     rd_req_q, rd_req_d;
  logic                     rd_out_q, rd_out_d;

  logic [31:0]              data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]         tag_mem  [NUM_LINES];

  logic                     dm_we;
  logic [IDX_W+OFF_W-1:0]   dm_idx;
  logic [31:0]              dm_wdata;
  logic [3:0]               dm_wmask;
  logic                     tag_we;

  logic [IDX_W-1:0]         req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic                     hit;

  assign req_idx = core.req_addr[OFF_W +: IDX_W];
  assign req_tag = core.req_addr[29 -: TAG_W];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign core.resp_ack  = resp_ack_q;
  assign core.resp_data = resp_data_q;

  // Control state register; data arrays and buffer payload are not reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      resp_ack_q  <= 1'b0;
      resp_data_q <= '0;
      wb_full_q   <= 1'b0;
      cnt_q       <= '0;
      rd_req_q    <= 1'b0;
      rd_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      resp_ack_q  <= resp_ack_d;
      resp_data_q <= resp_data_d;
      wb_full_q   <= wb_full_d;
      cnt_q       <= cnt_d;
      rd_req_q    <= rd_req_d;
      rd_out_q    <= rd_out_d;
    end
  end

  // Write-buffer payload and refill line address.
  always_ff @(posedge clk) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
    wb_mask_q <= wb_mask_d;
    line_q    <= line_d;
  end

  // Data and tag array writes: store-hit merges and refill words.
  always_ff @(posedge clk) begin
    if (dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_wmask[b]) data_mem[dm_idx][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
    if (tag_we) tag_mem[line_q[IDX_W-1:0]] <= line_q[LINE_W-1 -: TAG_W];
  end

  // Next-state: request decode, write-buffer drain, refill sequencing.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    resp_ack_d  = 1'b0;
    resp_data_d = '0;
    wb_full_d   = wb_full_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_mask_d   = wb_mask_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    rd_req_d    = rd_req_q;
    rd_out_d    = rd_out_q;
    dm_we       = 1'b0;
    dm_idx      = '0;
    dm_wdata    = '0;
    dm_wmask    = '0;
    tag_we      = 1'b0;

    // While full the buffer owns the backing port, so ready means it drained.
    if (wb_full_q && mem_req_ready) wb_full_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          if (!core.req_we) begin
            if (hit) begin
              resp_ack_d  = 1'b1;
              resp_data_d = data_mem[core.req_addr[IDX_W+OFF_W-1:0]];
            end else if (!wb_full_q) begin
              // Refetch only once memory holds every earlier store.
              state_d          = REFILL;
              line_d           = core.req_addr[29:OFF_W];
              cnt_d            = '0;
              rd_req_d         = 1'b1;
              valid_d[req_idx] = 1'b0;
            end
          end else if (core.req_mask == 4'b0) begin
            resp_ack_d = 1'b1;
          end else if (!wb_full_q || mem_req_ready) begin
            resp_ack_d = 1'b1;
            wb_full_d  = 1'b1;
            wb_addr_d  = core.req_addr;
            wb_data_d  = core.req_data;
            wb_mask_d  = core.req_mask;
            if (hit) begin
              dm_we    = 1'b1;
              dm_idx   = core.req_addr[IDX_W+OFF_W-1:0];
              dm_wdata = core.req_data;
              dm_wmask = core.req_mask;
            end
          end
        end
      end
      REFILL: begin
        if (rd_req_q && mem_req_ready) begin
          rd_req_d = 1'b0;
          rd_out_d = 1'b1;
        end
        if (rd_out_q && mem_resp_valid) begin
          rd_out_d = 1'b0;
          dm_we    = 1'b1;
          dm_idx   = {line_q[IDX_W-1:0], cnt_q};
          dm_wdata = mem_resp_data;
          dm_wmask = 4'hF;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            state_d                     = IDLE;
            valid_d[line_q[IDX_W-1:0]]  = 1'b1;
            tag_we                      = 1'b1;
          end else begin
            cnt_d    = cnt_q + OFF_W'(1);
            rd_req_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Backing-port outputs: the buffered write has priority; reads only exist
  // during a refill, when the buffer is always empty.
  always_comb begin
    mem_req_valid = wb_full_q | rd_req_q;
    mem_req_we    = wb_full_q;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    if (wb_full_q) begin
      mem_req_addr = wb_addr_q;
      mem_req_data = wb_data_q;
      mem_req_mask = wb_mask_q;
    end else if (rd_req_q) begin
      mem_req_addr = {line_q, cnt_q};
    end
  end
endmodule
